// File: rtl/input_debounce.sv
// input_debounce: synchronise, debounce and edge-detect a raw pad input
// Ports: clk; rst (async, active high); in (raw pad); tick (count enable);
//        clr (clears sticky flags); level (debounced); rise/fall (one-cycle
//        pulses); rise_seen/fall_seen (sticky event flags)
module input_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic tick,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_seen,
  output logic fall_seen
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic rise_seen_q, rise_seen_d, fall_seen_q, fall_seen_d;
  logic synced, differ, done;
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], in};
    synced      = sync_q[SYNC_STAGES-1];
    differ      = synced ^ level_q;
    done        = differ & tick & (cnt_q == LAST);
    // Agreement with level discards progress regardless of tick.
    cnt_d       = (!differ || done) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    level_d     = level_q ^ done;
    rise_d      = done & ~level_q;
    fall_d      = done & level_q;
    // A new event outranks a simultaneous clear.
    rise_seen_d = rise_q | (rise_seen_q & ~clr);
    fall_seen_d = fall_q | (fall_seen_q & ~clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q       <= '0;
      level_q     <= RESET_LEVEL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      rise_seen_q <= 1'b0;
      fall_seen_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rise_seen_q <= rise_seen_d;
      fall_seen_q <= fall_seen_d;
    end
  end
  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign rise_seen = rise_seen_q;
  assign fall_seen = fall_seen_q;
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed checks of input_debounce across four parameter sets
module tb_input_debounce;
  logic clk = 1'b0;
  logic rst, clr, tick, tick1, tick3;
  logic in0, in1, in2, in3;
  logic lv0, rs0, fl0, rss0, fss0;
  logic lv1, rs1, fl1, rss1, fss1;
  logic lv2, rs2, fl2, rss2, fss2;
  logic lv3, rs3, fl3, rss3, fss3;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  input_debounce u0 (.clk(clk), .rst(rst), .in(in0), .tick(tick), .clr(clr),
    .level(lv0), .rise(rs0), .fall(fl0), .rise_seen(rss0), .fall_seen(fss0));
  input_debounce #(.DEBOUNCE_CYCLES(4)) u1 (.clk(clk), .rst(rst), .in(in1), .tick(tick1), .clr(clr),
    .level(lv1), .rise(rs1), .fall(fl1), .rise_seen(rss1), .fall_seen(fss1));
  input_debounce #(.RESET_LEVEL(1'b1)) u2 (.clk(clk), .rst(rst), .in(in2), .tick(tick), .clr(clr),
    .level(lv2), .rise(rs2), .fall(fl2), .rise_seen(rss2), .fall_seen(fss2));
  input_debounce #(.DEBOUNCE_CYCLES(1)) u3 (.clk(clk), .rst(rst), .in(in3), .tick(tick3), .clr(clr),
    .level(lv3), .rise(rs3), .fall(fl3), .rise_seen(rss3), .fall_seen(fss3));
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; tick = 1'b1; tick1 = 1'b1; tick3 = 1'b1;
    in0 = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    #2;
    total++;
    if ({lv0, rs0, fl0, rss0, fss0} !== 5'b00000) begin
      bad++; $display("FAIL reset_u0 got=%b exp=00000", {lv0, rs0, fl0, rss0, fss0});
    end
    total++;
    if ({lv2, rs2, fl2, rss2, fss2} !== 5'b10000) begin
      bad++; $display("FAIL reset_u2 got=%b exp=10000", {lv2, rs2, fl2, rss2, fss2});
    end
    edges(2);
    rst = 1'b0;
  endtask
  task automatic test_reset_level1;
    edges(1);
    total++;
    if ({lv2, fl2, rs2} !== 3'b100) begin
      bad++; $display("FAIL rl1_release got=%b exp=100", {lv2, fl2, rs2});
    end
    edges(16);
    total++;
    if ({lv2, fl2} !== 2'b10) begin
      bad++; $display("FAIL rl1_edge17 got=%b exp=10", {lv2, fl2});
    end
    edges(1);
    total++;
    if ({lv2, fl2, rs2} !== 3'b010) begin
      bad++; $display("FAIL rl1_edge18 got=%b exp=010", {lv2, fl2, rs2});
    end
    edges(1);
    total++;
    if ({fl2, fss2} !== 2'b01) begin
      bad++; $display("FAIL rl1_edge19 got=%b exp=01", {fl2, fss2});
    end
  endtask
  task automatic test_glitch;
    in0 = 1'b1;
    edges(15);
    in0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if ({lv0, rs0} !== 2'b00) begin
        bad++; $display("FAIL glitch k=%0d got=%b exp=00", k, {lv0, rs0});
      end
      edges(1);
    end
  endtask
  task automatic test_step_rise;
    in0 = 1'b1;
    edges(17);
    total++;
    if ({lv0, rs0} !== 2'b00) begin
      bad++; $display("FAIL rise_edge17 got=%b exp=00", {lv0, rs0});
    end
    edges(1);
    total++;
    if ({lv0, rs0, fl0} !== 3'b110) begin
      bad++; $display("FAIL rise_edge18 got=%b exp=110", {lv0, rs0, fl0});
    end
    edges(1);
    total++;
    if ({lv0, rs0, fl0, rss0, fss0} !== 5'b10010) begin
      bad++; $display("FAIL rise_edge19 got=%b exp=10010", {lv0, rs0, fl0, rss0, fss0});
    end
  endtask
  task automatic test_fall;
    in0 = 1'b0;
    edges(17);
    total++;
    if ({lv0, fl0} !== 2'b10) begin
      bad++; $display("FAIL fall_edge17 got=%b exp=10", {lv0, fl0});
    end
    edges(1);
    total++;
    if ({lv0, rs0, fl0} !== 3'b001) begin
      bad++; $display("FAIL fall_edge18 got=%b exp=001", {lv0, rs0, fl0});
    end
    edges(1);
    total++;
    if ({fl0, rss0, fss0} !== 3'b011) begin
      bad++; $display("FAIL fall_edge19 got=%b exp=011", {fl0, rss0, fss0});
    end
  endtask
  task automatic test_sticky;
    in0 = 1'b1;
    edges(18);
    total++;
    if ({lv0, rs0, rss0} !== 3'b111) begin
      bad++; $display("FAIL sticky_rise got=%b exp=111", {lv0, rs0, rss0});
    end
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    total++;
    if ({rss0, fss0} !== 2'b10) begin
      bad++; $display("FAIL sticky_set_wins got=%b exp=10", {rss0, fss0});
    end
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    total++;
    if ({rss0, fss0} !== 2'b00) begin
      bad++; $display("FAIL sticky_clear got=%b exp=00", {rss0, fss0});
    end
  endtask
  task automatic test_tick;
    in1 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick1 = (k % 3 == 0);
      edges(1);
      total++;
      if ({lv1, rs1} !== {k >= 12, k == 12}) begin
        bad++; $display("FAIL tick k=%0d got=%b exp=%b", k, {lv1, rs1}, {k >= 12, k == 12});
      end
    end
    tick1 = 1'b1;
  endtask
  task automatic test_d1;
    in3 = 1'b1;
    edges(2);
    total++;
    if (lv3 !== 1'b0) begin
      bad++; $display("FAIL d1_edge2 got=%b exp=0", lv3);
    end
    edges(1);
    total++;
    if ({lv3, rs3} !== 2'b11) begin
      bad++; $display("FAIL d1_edge3 got=%b exp=11", {lv3, rs3});
    end
    in3 = 1'b0;
    tick3 = 1'b0;
    edges(5);
    total++;
    if ({lv3, fl3} !== 2'b10) begin
      bad++; $display("FAIL d1_hold got=%b exp=10", {lv3, fl3});
    end
    tick3 = 1'b1;
    edges(1);
    total++;
    if ({lv3, fl3} !== 2'b01) begin
      bad++; $display("FAIL d1_tick got=%b exp=01", {lv3, fl3});
    end
  endtask
  task automatic test_rst_mid;
    in0 = 1'b0;
    edges(20);
    total++;
    if ({lv0, fss0} !== 2'b01) begin
      bad++; $display("FAIL rstmid_pre got=%b exp=01", {lv0, fss0});
    end
    in0 = 1'b1;
    edges(12);
    rst = 1'b1;
    #1;
    total++;
    if ({lv0, rs0, fl0, rss0, fss0, lv2} !== 6'b000001) begin
      bad++; $display("FAIL rstmid_async got=%b exp=000001", {lv0, rs0, fl0, rss0, fss0, lv2});
    end
    edges(1);
    rst = 1'b0;
    edges(17);
    total++;
    if ({lv0, rs0} !== 2'b00) begin
      bad++; $display("FAIL rstmid_edge17 got=%b exp=00", {lv0, rs0});
    end
    edges(1);
    total++;
    if ({lv0, rs0} !== 2'b11) begin
      bad++; $display("FAIL rstmid_edge18 got=%b exp=11", {lv0, rs0});
    end
  endtask
  initial begin
    test_reset;
    test_reset_level1;
    test_glitch;
    test_step_rise;
    test_fall;
    test_sticky;
    test_tick;
    test_d1;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on the raw pad input; legal values are 2 or more.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive qualifying ticks a new level must persist; legal values are 1 or more.
REQ-003 SHALL have parameter RESET_LEVEL, default 0, the value held by the synchroniser and the level output during reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, 1 bit: raw, asynchronous pad input from the I/O pad cell.
REQ-007 SHALL have port tick, input, 1 bit: debounce-counter advance enable; tie high for per-clock debouncing.
REQ-008 SHALL have port clr, input, 1 bit: clears the sticky event flags.
REQ-009 SHALL have port level, output, 1 bit: the debounced input level.
REQ-010 SHALL have port rise, output, 1 bit: one-cycle pulse on each debounced 0->1 transition.
REQ-011 SHALL have port fall, output, 1 bit: one-cycle pulse on each debounced 1->0 transition.
REQ-012 SHALL have port rise_seen, output, 1 bit: sticky flag recording a rise since the last clr.
REQ-013 SHALL have port fall_seen, output, 1 bit: sticky flag recording a fall since the last clr.

Function
REQ-014 SHALL pass in through a chain of SYNC_STAGES flops; the output of the last flop is "synced"; no other logic SHALL sample in.
REQ-015 SHALL hold a counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-016 When synced equals level, the counter SHALL clear to 0 on every clock, independent of tick.
REQ-017 When synced differs from level, tick is high, and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-018 When synced differs from level, tick is high, and the counter equals DEBOUNCE_CYCLES-1, level SHALL invert and the counter SHALL clear to 0 on that same edge.
REQ-019 When synced differs from level and tick is low, the counter and level SHALL hold.
REQ-020 Any return of synced to the current level before the toggle SHALL discard all progress: the counter clears and level is unchanged.
REQ-021 With tick held high, a clean step on in first sampled at edge 1 SHALL change level at edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 18).
REQ-022 rise SHALL be registered and high for exactly the one cycle following the edge where level goes 0->1; fall SHALL behave the same for a 1->0 transition; rise and fall SHALL never be high together.
REQ-023 rise_seen SHALL set on any cycle in which rise is high, and fall_seen likewise on fall; each SHALL clear on the edge after clr is high.
REQ-024 If set and clr coincide for a flag, set SHALL win and the flag SHALL remain 1.
REQ-025 With DEBOUNCE_CYCLES=1, level SHALL follow synced with one tick of delay.

Reset
REQ-026 While rst is high, all outputs and state SHALL take their reset values asynchronously: synchroniser flops and level = RESET_LEVEL, counter = 0, rise = fall = rise_seen = fall_seen = 0.
REQ-027 Release of rst SHALL NOT generate a rise or fall pulse, even if in differs from RESET_LEVEL; such a difference SHALL be debounced normally per REQ-021.
REQ-028 Assertion of rst mid-count SHALL abandon the pending transition with no pulse.

Verification
REQ-029 Defaults, tick=1: step in 0->1 held -> level=1 and rise=1 for one cycle at edge 18; rise_seen=1 afterwards; fall stays 0.
REQ-030 Defaults, tick=1, level=0: in pulses high for 15 cycles, then returns low -> level stays 0, no rise, and the counter returns to 0.
REQ-031 DEBOUNCE_CYCLES=4, tick high every 3rd clock: a step on in -> level changes only after 4 tick-high cycles with synced differing; the count is frozen during tick-low cycles.
REQ-032 Sticky flags: rise_seen=1 and clr pulsed in the same cycle as a new rise -> rise_seen stays 1; a clr with no event -> rise_seen=0 the next cycle.
REQ-033 RESET_LEVEL=1 with in=0 at reset release -> no fall pulse at release; level=0 and fall=1 at edge 18.
REQ-034 rst asserted at count 10 -> counter=0 and level=RESET_LEVEL immediately, with no pulse; after release, debouncing restarts from zero.
